crono_ajuste_ctrl: RTL and testbench
====================================

# crono_ajuste_ctrl

Mode and adjustment controller for the chronometer counters (hours, minutes, seconds). It turns synchronous, already-debounced front-panel buttons into the shared 2-bit field select `EN` and into single-cycle `aumento`/`disminuye` pulses. It also gates chronometer counting through `crono_run`. It sits between the button conditioning logic and the `Cronometro_hora`-style field counters, and is the only driver of their `EN`, `aumento` and `disminuye` inputs.

## Interface
- `REPEAT_DLY`, 500: cycles a held up/down button waits after its first pulse before auto-repeat starts.
- `REPEAT_PER`, 100: cycles between auto-repeat pulses.
- `TIMEOUT`, 5000: cycles without any button edge in AJUSTE before automatic return to PARADO.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `btn_start` in 1: start/stop toggle.
- `btn_ajuste` in 1: enter/leave adjust mode.
- `btn_izq` in 1: select previous field.
- `btn_der` in 1: select next field.
- `btn_arriba` in 1: increment selected field.
- `btn_abajo` in 1: decrement selected field.
- `EN` out 2: field select. 0 = hours, 1 = minutes, 2 = seconds, 3 = none.
- `aumento` out 1: one-cycle increment pulse.
- `disminuye` out 1: one-cycle decrement pulse.
- `ajustando` out 1: high while in AJUSTE.
- `crono_run` out 1: high while in CORRE.

## Operation
- All button inputs are sampled every cycle. A press is a 0→1 transition between consecutive samples.
- The FSM has three states:
  - PARADO (reset state): `btn_start` press → CORRE; `btn_ajuste` press → AJUSTE with EN=0.
  - CORRE: `btn_start` press → PARADO. All other buttons are ignored.
  - AJUSTE: `btn_ajuste` press → PARADO; timeout → PARADO. `btn_start` is ignored.
- EN is 3 in PARADO and CORRE, so no field counter sees a select.
- EN in AJUSTE:
  - `btn_der` steps forward 0→1→2→0.
  - `btn_izq` steps backward 0→2→1→0.
  - Simultaneous izq+der presses leave EN unchanged.
- Pulse generation in AJUSTE:
  - An arriba press gives `aumento` = 1 for one cycle; an abajo press gives `disminuye` = 1 for one cycle.
  - If arriba and abajo are both high (new or held), neither pulse fires and both repeat engines are cleared.
  - `aumento` and `disminuye` are never high in the same cycle.
  - Both are 0 outside AJUSTE.
- Timeout counter: cleared on any button press and on entering AJUSTE; counts while in AJUSTE. When it reaches TIMEOUT-1, the next edge moves to PARADO.
- A field change (izq/der) clears both repeat engines.
- On reset: state PARADO, EN=3, all other outputs 0, all counters 0, edge-detect history 0.

## Timing
- Every output is registered.
- A button seen high at edge k after a low sample at edge k-1 gives its output effect in the cycle after edge k (one-cycle latency).
- State, EN and the pulse outputs update on the same edge.
- Auto-repeat:
  - The first repeat pulse comes REPEAT_DLY cycles after the initial pulse.
  - Later pulses come every REPEAT_PER cycles while the button stays high.
  - Release cancels the sequence immediately.
- Leaving AJUSTE (button or timeout) forces EN=3 and zero pulses on that edge. Any in-flight repeat is dropped.
- An asynchronous reset in any state takes effect immediately, with no pulse emitted.
- Counters are sized `$clog2(param)+1` bits and saturate; they never wrap.

## Configuration
- `CRONO_AUTOREPEAT_EN`:
  - Defined: held arriba/abajo auto-repeats as described in Timing.
  - Undefined: exactly one pulse per press; REPEAT_DLY and REPEAT_PER are unused and their counters are not built.

## Structure
- Shared package `crono_pkg` holds:
  - EN codes: `EN_HORA`=0, `EN_MIN`=1, `EN_SEG`=2, `EN_NINGUNO`=3.
  - FSM state enum: PARADO, CORRE, AJUSTE.
- Sub-module `crono_btn_rep` contains edge detect plus the auto-repeat counter for one button, with a clear input. It is instantiated twice, once for arriba and once for abajo.

## Test plan
- Release reset, press `btn_ajuste`, then hold `btn_arriba` 1 cycle → `ajustando` = 1, EN=0, `aumento` high exactly one cycle, one cycle after the press.
- In AJUSTE press `btn_der` three times, then `btn_izq` once → EN sequence 1, 2, 0, 2.
- With REPEAT_DLY=10, REPEAT_PER=4 and the macro defined, hold `btn_abajo` 30 cycles → `disminuye` pulses at offsets 0, 10, 14, 18, 22, 26. Without the macro → only the pulse at 0.
- In AJUSTE hold arriba and abajo together for 20 cycles → no `aumento`, no `disminuye`.
- With TIMEOUT=50, enter AJUSTE and stay idle → at cycle 50 state is PARADO, EN=3, `ajustando` = 0.
- Press `btn_start` (`crono_run` = 1), then pulse `btn_ajuste` and `btn_arriba` → no change. Assert `rst` low mid-repeat → outputs go to reset values immediately.

Source files
------------

// File: rtl/crono_pkg.sv
// Shared definitions for the chronometer adjust controller: field-select codes,
// controller states and field-step helpers.
package crono_pkg;

    localparam logic [1:0] EN_HORA    = 2'd0;
    localparam logic [1:0] EN_MIN     = 2'd1;
    localparam logic [1:0] EN_SEG     = 2'd2;
    localparam logic [1:0] EN_NINGUNO = 2'd3;

    typedef enum logic [1:0] {
        PARADO = 2'd0,
        CORRE  = 2'd1,
        AJUSTE = 2'd2
    } crono_state_e;

    // Field order wraps hours -> minutes -> seconds -> hours.
    function automatic logic [1:0] en_siguiente(input logic [1:0] en);
        return (en == EN_SEG) ? EN_HORA : en + 2'd1;
    endfunction

    function automatic logic [1:0] en_anterior(input logic [1:0] en);
        return (en == EN_HORA) ? EN_SEG : en - 2'd1;
    endfunction

endpackage

// File: rtl/crono_btn_rep.sv
// Edge detect plus optional hold-to-repeat engine for one up/down button.
// Auto-repeat counter exists only when CRONO_AUTOREPEAT_EN is defined.
module crono_btn_rep
    import crono_pkg::*;
`ifdef CRONO_AUTOREPEAT_EN
#(
    parameter int DLY = 500,
    parameter int PER = 100
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic clr,
    output logic press,
    output logic fire
);

    logic prev_q;
    logic armed_q, armed_d;

`ifdef CRONO_AUTOREPEAT_EN
    localparam int MAXP = (DLY > PER) ? DLY : PER;
    localparam int CW   = $clog2(MAXP) + 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          per_q, per_d;
    logic [CW-1:0] limit;

    // Before the first repeat we wait DLY cycles, afterwards PER cycles.
    assign limit = per_q ? CW'(PER - 1) : CW'(DLY - 1);
`endif

    assign press = btn & ~prev_q;

    always_comb begin
        fire    = 1'b0;
        armed_d = armed_q;
`ifdef CRONO_AUTOREPEAT_EN
        cnt_d   = cnt_q;
        per_d   = per_q;
`endif
        if (clr) begin
            armed_d = 1'b0;
`ifdef CRONO_AUTOREPEAT_EN
            cnt_d   = '0;
            per_d   = 1'b0;
`endif
        end else if (press) begin
            armed_d = 1'b1;
            fire    = 1'b1;
`ifdef CRONO_AUTOREPEAT_EN
            cnt_d   = '0;
            per_d   = 1'b0;
`endif
        end else if (armed_q && btn) begin
`ifdef CRONO_AUTOREPEAT_EN
            if (cnt_q == limit) begin
                fire  = 1'b1;
                cnt_d = '0;
                per_d = 1'b1;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
`endif
        end else begin
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
`ifdef CRONO_AUTOREPEAT_EN
            cnt_q   <= '0;
            per_q   <= 1'b0;
`endif
        end else begin
            prev_q  <= btn;
            armed_q <= armed_d;
`ifdef CRONO_AUTOREPEAT_EN
            cnt_q   <= cnt_d;
            per_q   <= per_d;
`endif
        end
    end

endmodule

// File: rtl/crono_ajuste_ctrl.sv
// Mode/adjust controller: PARADO/CORRE/AJUSTE FSM, field select EN and up/down pulses.
// Held-button auto-repeat is built only when CRONO_AUTOREPEAT_EN is defined.
module crono_ajuste_ctrl
    import crono_pkg::*;
#(
    parameter int REPEAT_DLY = 500,
    parameter int REPEAT_PER = 100,
    parameter int TIMEOUT    = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_ajuste,
    input  logic       btn_izq,
    input  logic       btn_der,
    input  logic       btn_arriba,
    input  logic       btn_abajo,
    output logic [1:0] EN,
    output logic       aumento,
    output logic       disminuye,
    output logic       ajustando,
    output logic       crono_run
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    if (REPEAT_DLY < 1 || REPEAT_PER < 1 || TIMEOUT < 2) begin : g_bad_cfg
        $error("crono_ajuste_ctrl: REPEAT_DLY/REPEAT_PER must be >= 1 and TIMEOUT >= 2");
    end

    crono_state_e  state_q, state_d;
    logic [1:0]    en_q, en_d;
    logic          aum_q, aum_d;
    logic          dis_q, dis_d;
    logic          ajust_q, ajust_d;
    logic          run_q, run_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    prev_q;

    logic [3:0] btn_v;
    logic [3:0] press_v;
    logic       up_press, dn_press, up_fire, dn_fire;
    logic       rep_clr, any_press;

    // Bit order: 0 start, 1 ajuste, 2 izq, 3 der.
    assign btn_v     = {btn_der, btn_izq, btn_ajuste, btn_start};
    assign press_v   = btn_v & ~prev_q;
    assign any_press = (|press_v) | up_press | dn_press;

`ifdef CRONO_AUTOREPEAT_EN
    crono_btn_rep #(.DLY(REPEAT_DLY), .PER(REPEAT_PER)) u_rep_arriba (
`else
    crono_btn_rep u_rep_arriba (
`endif
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_arriba),
        .clr   (rep_clr),
        .press (up_press),
        .fire  (up_fire)
    );

`ifdef CRONO_AUTOREPEAT_EN
    crono_btn_rep #(.DLY(REPEAT_DLY), .PER(REPEAT_PER)) u_rep_abajo (
`else
    crono_btn_rep u_rep_abajo (
`endif
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_abajo),
        .clr   (rep_clr),
        .press (dn_press),
        .fire  (dn_fire)
    );

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        aum_d   = 1'b0;
        dis_d   = 1'b0;
        tmo_d   = tmo_q;
        rep_clr = 1'b1;
        unique case (state_q)
            PARADO: begin
                if (press_v[0]) begin
                    state_d = CORRE;
                end else if (press_v[1]) begin
                    state_d = AJUSTE;
                    en_d    = EN_HORA;
                    tmo_d   = '0;
                end
            end
            CORRE: begin
                if (press_v[0]) state_d = PARADO;
            end
            AJUSTE: begin
                // A press on the timeout edge keeps us adjusting.
                if (press_v[1] || (!any_press && tmo_q == TW'(TIMEOUT - 1))) begin
                    state_d = PARADO;
                    en_d    = EN_NINGUNO;
                end else begin
                    if (any_press)        tmo_d = '0;
                    else if (tmo_q != '1) tmo_d = tmo_q + 1'b1;
                    if (press_v[3] && !press_v[2])      en_d = en_siguiente(en_q);
                    else if (press_v[2] && !press_v[3]) en_d = en_anterior(en_q);
                    rep_clr = press_v[2] | press_v[3] | (btn_arriba & btn_abajo);
                    aum_d   = up_fire;
                    dis_d   = dn_fire;
                end
            end
            default: begin
                state_d = PARADO;
                en_d    = EN_NINGUNO;
            end
        endcase
        ajust_d = (state_d == AJUSTE);
        run_d   = (state_d == CORRE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PARADO;
            en_q    <= EN_NINGUNO;
            aum_q   <= 1'b0;
            dis_q   <= 1'b0;
            ajust_q <= 1'b0;
            run_q   <= 1'b0;
            tmo_q   <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            aum_q   <= aum_d;
            dis_q   <= dis_d;
            ajust_q <= ajust_d;
            run_q   <= run_d;
            tmo_q   <= tmo_d;
            prev_q  <= btn_v;
        end
    end

    assign EN        = en_q;
    assign aumento   = aum_q;
    assign disminuye = dis_q;
    assign ajustando = ajust_q;
    assign crono_run = run_q;

endmodule

// File: tb/tb_crono_ajuste_ctrl.sv
// Bench for crono_ajuste_ctrl: directed scenarios plus random button traffic,
// all outputs compared each cycle against an elapsed-time behavioural model.
module tb_crono_ajuste_ctrl;

    localparam int DLY = 10;
    localparam int PER = 4;
    localparam int TMO = 50;
`ifdef CRONO_AUTOREPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    localparam logic [5:0] B_START  = 6'b000001;
    localparam logic [5:0] B_AJUSTE = 6'b000010;
    localparam logic [5:0] B_IZQ    = 6'b000100;
    localparam logic [5:0] B_DER    = 6'b001000;
    localparam logic [5:0] B_ARRIBA = 6'b010000;
    localparam logic [5:0] B_ABAJO  = 6'b100000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] b   = '0;
    logic [1:0] EN;
    logic       aumento, disminuye, ajustando, crono_run;

    always #5 clk = ~clk;

    crono_ajuste_ctrl #(
        .REPEAT_DLY (DLY),
        .REPEAT_PER (PER),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_start  (b[0]),
        .btn_ajuste (b[1]),
        .btn_izq    (b[2]),
        .btn_der    (b[3]),
        .btn_arriba (b[4]),
        .btn_abajo  (b[5]),
        .EN         (EN),
        .aumento    (aumento),
        .disminuye  (disminuye),
        .ajustando  (ajustando),
        .crono_run  (crono_run)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_aum   = 0;
    int n_dis   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    // Model: 0 = stopped, 1 = running, 2 = adjusting. Repeat timing is derived
    // from k = cycles elapsed since the arming press.
    int         m_state, m_en, m_tmo, k_u, k_d;
    bit         m_aum, m_dis, arm_u, arm_d;
    logic [5:0] m_prev;

    task automatic model_reset();
        m_state = 0; m_en = 3; m_tmo = 0;
        m_aum = 0; m_dis = 0;
        arm_u = 0; arm_d = 0; k_u = 0; k_d = 0;
        m_prev = '0;
    endtask

    task automatic engine(input bit held, input bit pr, inout bit arm, inout int k, output bit fire);
        fire = 0;
        if (pr) begin
            arm = 1; k = 0; fire = 1;
        end else if (arm && held) begin
            k++;
            fire = REP && (k >= DLY) && (((k - DLY) % PER) == 0);
        end else begin
            arm = 0;
        end
    endtask

    task automatic model_step();
        logic [5:0] pr;
        bit fu, fd;
        pr = b & ~m_prev;
        m_prev = b;
        m_aum = 0; m_dis = 0;
        case (m_state)
            0: begin
                arm_u = 0; arm_d = 0;
                if (pr[0]) m_state = 1;
                else if (pr[1]) begin m_state = 2; m_en = 0; m_tmo = 0; end
            end
            1: begin
                arm_u = 0; arm_d = 0;
                if (pr[0]) m_state = 0;
            end
            default: begin
                if (pr[1] || (pr == 0 && m_tmo == TMO - 1)) begin
                    m_state = 0; m_en = 3; arm_u = 0; arm_d = 0;
                end else begin
                    m_tmo = (pr != 0) ? 0 : m_tmo + 1;
                    if (pr[3] && !pr[2])      m_en = (m_en + 1) % 3;
                    else if (pr[2] && !pr[3]) m_en = (m_en + 2) % 3;
                    if (pr[2] || pr[3] || (b[4] && b[5])) begin
                        arm_u = 0; arm_d = 0;
                    end else begin
                        engine(b[4], pr[4], arm_u, k_u, fu);
                        engine(b[5], pr[5], arm_d, k_d, fd);
                        m_aum = fu; m_dis = fd;
                    end
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("EN",        {30'd0, EN},        m_en);
        check("aumento",   {31'd0, aumento},   {31'd0, m_aum});
        check("disminuye", {31'd0, disminuye}, {31'd0, m_dis});
        check("ajustando", {31'd0, ajustando}, (m_state == 2) ? 1 : 0);
        check("crono_run", {31'd0, crono_run}, (m_state == 1) ? 1 : 0);
    endtask

    // Starts and ends on a falling edge.
    task automatic cycle(input logic [5:0] bv);
        b = bv;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        if (aumento)   n_aum++;
        if (disminuye) n_dis++;
    endtask

    initial begin
        logic [5:0] r;
        int exp_en [3];
        exp_en[0] = 1; exp_en[1] = 2; exp_en[2] = 0;

        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        check("reset_EN", {30'd0, EN}, 3);
        rst = 1'b1;

        // Enter adjust, single increment.
        cycle(B_AJUSTE);
        check("enter_ajustando", {31'd0, ajustando}, 1);
        check("enter_EN", {30'd0, EN}, 0);
        cycle(B_ARRIBA);
        check("first_aumento", {31'd0, aumento}, 1);
        cycle('0);
        check("aumento_one_cycle", {31'd0, aumento}, 0);

        // Field stepping.
        for (int i = 0; i < 3; i++) begin
            cycle(B_DER);
            check("der_EN", {30'd0, EN}, exp_en[i]);
            cycle('0);
        end
        cycle(B_IZQ);
        check("izq_EN", {30'd0, EN}, 2);
        cycle('0);

        // Held abajo: 6 pulses with repeat, otherwise 1.
        n_dis = 0;
        repeat (30) cycle(B_ABAJO);
        check("hold_abajo_pulses", n_dis, REP ? 6 : 1);
        cycle('0);

        // Both held: nothing.
        n_aum = 0; n_dis = 0;
        repeat (20) cycle(B_ARRIBA | B_ABAJO);
        check("both_held_pulses", n_aum + n_dis, 0);
        cycle('0);

        // Leave, re-enter and time out.
        cycle(B_AJUSTE);
        check("leave_ajustando", {31'd0, ajustando}, 0);
        cycle('0);
        cycle(B_AJUSTE);
        repeat (TMO - 1) cycle('0);
        check("pre_timeout_ajustando", {31'd0, ajustando}, 1);
        cycle('0);
        check("timeout_ajustando", {31'd0, ajustando}, 0);
        check("timeout_EN", {30'd0, EN}, 3);

        // Running ignores adjust buttons.
        cycle(B_START);
        check("run_crono_run", {31'd0, crono_run}, 1);
        cycle('0);
        cycle(B_AJUSTE);
        cycle('0);
        n_aum = 0;
        cycle(B_ARRIBA);
        cycle('0);
        check("run_ignore_ajust", {31'd0, ajustando}, 0);
        check("run_ignore_aum", n_aum, 0);
        check("run_still_running", {31'd0, crono_run}, 1);
        cycle(B_START);
        cycle('0);

        // Async reset in the middle of a repeat sequence.
        cycle(B_AJUSTE);
        cycle('0);
        repeat (15) cycle(B_ARRIBA);
        #2 rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("async_rst_EN", {30'd0, EN}, 3);
        b = '0;
        @(negedge clk);
        rst = 1'b1;
        cycle('0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r = b;
            if ($urandom_range(0, 39) == 0) r[0] = ~r[0];
            if ($urandom_range(0, 24) == 0) r[1] = ~r[1];
            if ($urandom_range(0, 11) == 0) r[2] = ~r[2];
            if ($urandom_range(0, 11) == 0) r[3] = ~r[3];
            if ($urandom_range(0, 9)  == 0) r[4] = ~r[4];
            if ($urandom_range(0, 9)  == 0) r[5] = ~r[5];
            cycle(r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
